// File: rtl/motor_pkg.sv
// Shared motor-control definitions: FSM states, PWM geometry and default timing.
package motor_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    COAST = 1'b1
  } motor_state_t;

  localparam int   PWM_TOP = 254;
  localparam logic DIR_FWD = 1'b1;

  // Also consumed by the triangle generator's clock scaling.
  localparam int PRESCALE_DEFAULT         = 390;
  localparam int DEADTIME_PERIODS_DEFAULT = 2;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: cclk prescaler feeding an 8-bit counter that spans 0..PWM_TOP.
module pwm_timebase
  import motor_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic       cclk,
  input  logic       rstb,
  output logic       tick,
  output logic       boundary,
  output logic [7:0] pwm_cnt
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  CNT_TOP  = 8'(PWM_TOP);

  logic [15:0] prescaler;

  assign tick     = (prescaler == PRE_LAST);
  assign boundary = tick && (pwm_cnt == CNT_TOP);

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 16'd1;
      if (tick) begin
        pwm_cnt <= (pwm_cnt == CNT_TOP) ? '0 : pwm_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Signed velocity to H-bridge direction + PWM, with a forced coast interval
// on every direction reversal.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PRESCALE         = PRESCALE_DEFAULT,
  parameter int DEADTIME_PERIODS = DEADTIME_PERIODS_DEFAULT
) (
  input  logic       cclk,
  input  logic       rstb,
  input  logic [7:0] velocity,
  input  logic       enable,
  output logic       pwm,
  output logic       dir,
  output logic       reversing,
  output logic       period_strobe
);

  localparam logic [3:0] DEAD_INIT = 4'(DEADTIME_PERIODS);

  logic         tick;
  logic         boundary;
  logic [7:0]   pwm_cnt;
  motor_state_t state, state_nxt;
  logic [7:0]   duty, duty_nxt;
  logic         dir_nxt;
  logic [3:0]   dead_cnt, dead_nxt;
  logic signed [7:0] vel_s;
  logic         opposite;
  logic         at_boundary;

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .cclk    (cclk),
    .rstb    (rstb),
    .tick    (tick),
    .boundary(boundary),
    .pwm_cnt (pwm_cnt)
  );

  // |v| saturated to 7 bits, doubled so full scale lands on PWM_TOP.
  function automatic logic [7:0] duty_of(input logic signed [7:0] v);
    logic [7:0] mag;
    if (v == 8'sh80) begin
      mag = 8'd127;
    end else if (v < 8'sd0) begin
      mag = 8'(-v);
    end else begin
      mag = 8'(v);
    end
    return {mag[6:0], 1'b0};
  endfunction

  assign vel_s       = velocity;
  assign at_boundary = tick && boundary;
  // Negative command while forward, or positive while reverse; zero never reverses.
  assign opposite    = (vel_s != 8'sd0) && (vel_s[7] == dir);

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    dir_nxt   = dir;
    dead_nxt  = dead_cnt;
    if (at_boundary) begin
      case (state)
        RUN: begin
          if (opposite) begin
            duty_nxt  = '0;
            dead_nxt  = DEAD_INIT;
            state_nxt = COAST;
          end else begin
            duty_nxt = duty_of(vel_s);
          end
        end
        COAST: begin
          dead_nxt = dead_cnt - 4'd1;
          if (dead_cnt == 4'd1) begin
            if (opposite) begin
              dir_nxt = ~dir;
            end
            duty_nxt  = duty_of(vel_s);
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state         <= RUN;
      duty          <= '0;
      dir           <= DIR_FWD;
      dead_cnt      <= '0;
      pwm           <= 1'b0;
      reversing     <= 1'b0;
      period_strobe <= 1'b0;
    end else begin
      state         <= state_nxt;
      duty          <= duty_nxt;
      dir           <= dir_nxt;
      dead_cnt      <= dead_nxt;
      pwm           <= enable && (pwm_cnt < duty) && (state == RUN);
      reversing     <= (state_nxt == COAST);
      period_strobe <= at_boundary;
    end
  end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver at PRESCALE=2 (510-cycle period), DEADTIME_PERIODS=2.
module tb_motor_pwm_driver;

  localparam int PERIOD = 510;

  logic       cclk = 1'b0;
  logic       rstb;
  logic [7:0] velocity;
  logic       enable;
  logic       pwm;
  logic       dir;
  logic       reversing;
  logic       period_strobe;

  int n_chk = 0;
  int n_err = 0;

  motor_pwm_driver #(
    .PRESCALE        (2),
    .DEADTIME_PERIODS(2)
  ) dut (
    .cclk         (cclk),
    .rstb         (rstb),
    .velocity     (velocity),
    .enable       (enable),
    .pwm          (pwm),
    .dir          (dir),
    .reversing    (reversing),
    .period_strobe(period_strobe)
  );

  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedges until period_strobe is seen; -1 if it never comes.
  task automatic wait_strobe(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 3 * PERIOD; i++) begin
      @(negedge cclk);
      if (period_strobe) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Called at a strobe negedge; samples one full period and ends on the next strobe.
  task automatic run_period(output int hi, output int first, output int last,
                            output int rev, output int dir_end);
    hi = 0; first = 0; last = 0; rev = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge cclk);
      if (pwm) begin
        hi++;
        if (first == 0) first = i;
        last = i;
      end
      if (reversing) rev++;
    end
    dir_end = int'(dir);
    chk("strobe_align", int'(period_strobe), 1);
  endtask

  int cyc, hi, first, last, rev, dend, hi_off;

  initial begin
    rstb     = 1'b0;
    enable   = 1'b1;
    velocity = 8'd50;

    // Reset
    repeat (3) @(negedge cclk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_rev", int'(reversing), 0);
    chk("rst_strobe", int'(period_strobe), 0);
    rstb     = 1'b1;
    velocity = 8'd64;
    wait_strobe(cyc);
    chk("first_strobe", cyc, 510);

    // Forward duty +64 -> 256 high cycles per period
    run_period(hi, first, last, rev, dend);
    chk("fwd_hi", hi, 256);
    chk("fwd_first", first, 1);
    chk("fwd_contig", last - first + 1, 256);
    chk("fwd_dir", dend, 1);
    chk("fwd_rev", rev, 0);
    velocity = 8'h80;
    run_period(hi, first, last, rev, dend);
    chk("fwd2_hi", hi, 256);

    // Reversal to -128: two coast periods, then saturated duty
    run_period(hi, first, last, rev, dend);
    chk("coast1_hi", hi, 0);
    chk("coast1_rev", rev, 510);
    chk("coast1_dir", dend, 1);
    run_period(hi, first, last, rev, dend);
    chk("coast2_hi", hi, 0);
    chk("coast2_rev", rev, 509);
    chk("coast2_dir", dend, 0);
    run_period(hi, first, last, rev, dend);
    chk("sat_hi", hi, 508);
    chk("sat_first", first, 1);
    chk("sat_last", last, 508);
    chk("sat_dir", dend, 0);

    // Aborted reversal from a fresh reset at +100
    rstb = 1'b0;
    @(negedge cclk);
    rstb     = 1'b1;
    velocity = 8'd100;
    wait_strobe(cyc);
    chk("abort_sync", cyc, 510);
    velocity = 8'(-100);
    run_period(hi, first, last, rev, dend);
    chk("abort_pre_hi", hi, 400);
    velocity = 8'd50;
    run_period(hi, first, last, rev, dend);
    chk("abort_c1_hi", hi, 0);
    chk("abort_c1_rev", rev, 510);
    run_period(hi, first, last, rev, dend);
    chk("abort_c2_hi", hi, 0);
    chk("abort_c2_rev", rev, 509);
    chk("abort_c2_dir", dend, 1);
    run_period(hi, first, last, rev, dend);
    chk("abort_hi", hi, 200);
    chk("abort_last", last, 200);
    chk("abort_dir", dend, 1);

    // Enable dropped mid-period at +100
    velocity = 8'd100;
    run_period(hi, first, last, rev, dend);
    hi_off = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge cclk);
      if (i == 100) begin
        chk("en_before", int'(pwm), 1);
        enable = 1'b0;
      end
      if (i == 101) chk("en_drop", int'(pwm), 0);
      if (i > 100 && i <= 300 && pwm) hi_off++;
      if (i == 300) enable = 1'b1;
      if (i == 301) chk("en_return", int'(pwm), 1);
    end
    chk("en_off_hi", hi_off, 0);

    // Zero velocity
    velocity = 8'd0;
    run_period(hi, first, last, rev, dend);
    run_period(hi, first, last, rev, dend);
    chk("zero_hi", hi, 0);
    chk("zero_dir", dend, 1);
    chk("zero_rev", rev, 0);

    // Reset in the middle of a coast
    velocity = 8'(-60);
    run_period(hi, first, last, rev, dend);
    chk("mc_pre_hi", hi, 0);
    chk("mc_enter", int'(reversing), 1);
    repeat (100) @(negedge cclk);
    chk("mc_mid", int'(reversing), 1);
    rstb = 1'b0;
    @(negedge cclk);
    chk("mc_rst_pwm", int'(pwm), 0);
    chk("mc_rst_rev", int'(reversing), 0);
    chk("mc_rst_dir", int'(dir), 1);
    chk("mc_rst_strobe", int'(period_strobe), 0);
    rstb = 1'b1;
    wait_strobe(cyc);
    chk("mc_restart", cyc, 510);
    chk("mc_recoast", int'(reversing), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
